// File: rtl/kitchen_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : kitchen_timer_ctrl
// Purpose  : MM:SS kitchen timer controller. Four BCD digit registers count
//            down once per second as a 10/6/10/6 borrow chain. Single-cycle
//            debounced buttons sequence set / run / pause / alarm.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous active-low reset
//            btn_start  - start/pause toggle, alarm acknowledge (pulse)
//            btn_min    - minutes +1 (pulse, IDLE/PAUSE only)
//            btn_sec    - seconds +1 (pulse, IDLE/PAUSE only)
//            btn_clr    - clear to 00:00 (pulse)
//            sec_lo/sec_hi/min_lo/min_hi - BCD display digits
//            running    - high in RUN
//            alarm      - high in ALARM
//            tick       - one-cycle pulse on each 1 s wrap in RUN/ALARM
//            beep       - 1 Hz 50 % buzzer pattern in ALARM
//                         (only when KTIMER_BEEP_EN is defined)
// Options  : `define KTIMER_BEEP_EN adds the beep output and its logic.
// Revision : 1.0 - initial release
// ============================================================================
module kitchen_timer_ctrl #(
  parameter int CLK_HZ    = 50000000,
  parameter int ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic       btn_clr,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic       running,
  output logic       alarm,
  output logic       tick
`ifdef KTIMER_BEEP_EN
  ,
  output logic       beep
`endif
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int AW = (ALARM_SEC > 0) ? $clog2(ALARM_SEC + 1) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
  localparam logic [AW-1:0] ALARM_LIM  = AW'(ALARM_SEC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [AW-1:0] acnt, acnt_n;
  logic [3:0]    sec_lo_n, sec_hi_n, min_lo_n, min_hi_n;
  logic          tick_n;
  logic          wrap, time_zero, time_one;
  logic [7:0]    min_inc, sec_inc;
  logic [AW-1:0] acnt_inc;

  // Two-digit BCD increment for 00..59 with wrap to 00.
  function automatic logic [7:0] bcd59_inc(input logic [3:0] hi, input logic [3:0] lo);
    logic [3:0] nhi, nlo;
    if (lo == 4'd9) begin
      nlo = 4'd0;
      nhi = (hi == 4'd5) ? 4'd0 : hi + 4'd1;
    end else begin
      nlo = lo + 4'd1;
      nhi = hi;
    end
    return {nhi, nlo};
  endfunction

  assign wrap      = (presc == PRESC_MAX);
  assign time_zero = ({min_hi, min_lo, sec_hi, sec_lo} == 16'h0000);
  assign time_one  = ({min_hi, min_lo, sec_hi, sec_lo} == 16'h0001);
  assign min_inc   = bcd59_inc(min_hi, min_lo);
  assign sec_inc   = bcd59_inc(sec_hi, sec_lo);
  assign acnt_inc  = acnt + 1'b1;

  always_comb begin
    state_n  = state;
    presc_n  = '0;          // prescaler rests at 0 unless RUN/ALARM counts it
    acnt_n   = acnt;
    tick_n   = 1'b0;
    sec_lo_n = sec_lo;
    sec_hi_n = sec_hi;
    min_lo_n = min_lo;
    min_hi_n = min_hi;

    case (state)
      ST_IDLE, ST_PAUSE: begin
        if (btn_clr) begin
          state_n = ST_IDLE;
          {min_hi_n, min_lo_n, sec_hi_n, sec_lo_n} = 16'h0000;
        end else if (btn_start) begin
          if (!time_zero)            state_n = ST_RUN;
          else if (state == ST_PAUSE) state_n = ST_IDLE;
        end else if (btn_min) begin
          {min_hi_n, min_lo_n} = min_inc;
        end else if (btn_sec) begin
          {sec_hi_n, sec_lo_n} = sec_inc;
        end
      end

      ST_RUN: begin
        if (btn_clr) begin
          state_n = ST_IDLE;
          {min_hi_n, min_lo_n, sec_hi_n, sec_lo_n} = 16'h0000;
        end else if (btn_start) begin
          state_n = ST_PAUSE;
        end else begin
          presc_n = wrap ? '0 : presc + 1'b1;
          if (wrap) begin
            tick_n = 1'b1;
            if (!time_zero) begin
              // Borrow chain: each digit wraps to its max and borrows upward.
              if (sec_lo != 4'd0) begin
                sec_lo_n = sec_lo - 4'd1;
              end else begin
                sec_lo_n = 4'd9;
                if (sec_hi != 4'd0) begin
                  sec_hi_n = sec_hi - 4'd1;
                end else begin
                  sec_hi_n = 4'd5;
                  if (min_lo != 4'd0) begin
                    min_lo_n = min_lo - 4'd1;
                  end else begin
                    min_lo_n = 4'd9;
                    min_hi_n = min_hi - 4'd1;
                  end
                end
              end
            end
            if (time_one) begin
              state_n = ST_ALARM;
              acnt_n  = '0;
            end
          end
        end
      end

      ST_ALARM: begin
        if (btn_clr || btn_start) begin
          state_n = ST_IDLE;
        end else begin
          presc_n = wrap ? '0 : presc + 1'b1;
          if (wrap) begin
            tick_n = 1'b1;
            acnt_n = acnt_inc;
            if (acnt_inc == ALARM_LIM) state_n = ST_IDLE;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      presc   <= '0;
      acnt    <= '0;
      sec_lo  <= 4'd0;
      sec_hi  <= 4'd0;
      min_lo  <= 4'd0;
      min_hi  <= 4'd0;
      running <= 1'b0;
      alarm   <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      acnt    <= acnt_n;
      sec_lo  <= sec_lo_n;
      sec_hi  <= sec_hi_n;
      min_lo  <= min_lo_n;
      min_hi  <= min_hi_n;
      running <= (state_n == ST_RUN);
      alarm   <= (state_n == ST_ALARM);
      tick    <= tick_n;
    end
  end

`ifdef KTIMER_BEEP_EN
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);

  // Registered against the next prescaler value so beep lines up with the
  // prescaler phase and starts high on the ALARM entry edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) beep <= 1'b0;
    else        beep <= (state_n == ST_ALARM) && (presc_n < PRESC_HALF);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_kitchen_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_kitchen_timer_ctrl
// Purpose  : Directed bench for kitchen_timer_ctrl with CLK_HZ=4,
//            ALARM_SEC=10. Expected display/status words are queued when
//            stimulus is applied and popped when the outputs are sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kitchen_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_start = 1'b0, btn_min = 1'b0, btn_sec = 1'b0, btn_clr = 1'b0;
  logic [3:0] sec_lo, sec_hi, min_lo, min_hi;
  logic       running, alarm, tick;
`ifdef KTIMER_BEEP_EN
  logic       beep;
`endif

  kitchen_timer_ctrl #(.CLK_HZ(4), .ALARM_SEC(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_start (btn_start),
    .btn_min   (btn_min),
    .btn_sec   (btn_sec),
    .btn_clr   (btn_clr),
    .sec_lo    (sec_lo),
    .sec_hi    (sec_hi),
    .min_lo    (min_lo),
    .min_hi    (min_hi),
    .running   (running),
    .alarm     (alarm),
    .tick      (tick)
`ifdef KTIMER_BEEP_EN
    ,
    .beep      (beep)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [18:0] exp;   // {running, alarm, tick, MM:SS as BCD}
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    passes = 0;
  int    fails  = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic pulse(input logic s, input logic m, input logic sc, input logic c);
    btn_start = s; btn_min = m; btn_sec = sc; btn_clr = c;
    cyc();
    btn_start = 1'b0; btn_min = 1'b0; btn_sec = 1'b0; btn_clr = 1'b0;
  endtask

  task automatic push_exp(input string tag, input logic r, input logic a,
                          input logic t, input logic [15:0] tm);
    item_t it;
    it.tag = tag;
    it.exp = {r, a, t, tm};
    sb.push_back(it);
  endtask

  task automatic cmp();
    item_t       it;
    logic [18:0] obs;
    obs = {running, alarm, tick, min_hi, min_lo, sec_hi, sec_lo};
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp) passes++;
      else begin
        fails++;
        $error("FAIL %s observed run/alm/tick=%b%b%b time=%h expected run/alm/tick=%b%b%b time=%h",
               it.tag, obs[18], obs[17], obs[16], obs[15:0],
               it.exp[18], it.exp[17], it.exp[16], it.exp[15:0]);
      end
    end
  endtask

  task automatic expect_now(input string tag, input logic r, input logic a,
                            input logic t, input logic [15:0] tm);
    push_exp(tag, r, a, t, tm);
    cmp();
  endtask

`ifdef KTIMER_BEEP_EN
  task automatic chk_beep(input string tag, input logic e);
    checks++;
    assert (beep === e) passes++;
    else begin
      fails++;
      $error("FAIL %s observed beep=%b expected beep=%b", tag, beep, e);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held low, then released.
    cyc();
    expect_now("rst_low", 1'b0, 1'b0, 1'b0, 16'h0000);
    reset = 1'b1;
    cyc();
    expect_now("rst_rel", 1'b0, 1'b0, 1'b0, 16'h0000);

    // Set 01:02 and run through the borrow path.
    pulse(0, 0, 1, 0);
    pulse(0, 0, 1, 0);
    pulse(0, 1, 0, 0);
    expect_now("set_0102", 1'b0, 1'b0, 1'b0, 16'h0102);
    push_exp("start", 1'b1, 1'b0, 1'b0, 16'h0102);
    pulse(1, 0, 0, 0);
    cmp();
    cycles(3);
    expect_now("pre_tick", 1'b1, 1'b0, 1'b0, 16'h0102);
    cyc();
    expect_now("tick1", 1'b1, 1'b0, 1'b1, 16'h0101);
    cycles(4);
    expect_now("dec_0100", 1'b1, 1'b0, 1'b1, 16'h0100);
    cycles(4);
    expect_now("borrow_0059", 1'b1, 1'b0, 1'b1, 16'h0059);
    cycles(4);
    expect_now("dec_0058", 1'b1, 1'b0, 1'b1, 16'h0058);

    // Asynchronous reset mid-RUN.
    cycles(2);
    #2 reset = 1'b0;
    #1;
    expect_now("rst_async", 1'b0, 1'b0, 1'b0, 16'h0000);
    cyc();
    expect_now("rst_hold", 1'b0, 1'b0, 1'b0, 16'h0000);
    reset = 1'b1;
    cyc();
    expect_now("rst_rel2", 1'b0, 1'b0, 1'b0, 16'h0000);

    // Expiry into ALARM and automatic return to IDLE.
    pulse(0, 0, 1, 0);
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    expect_now("start_0002", 1'b1, 1'b0, 1'b0, 16'h0002);
    cycles(4);
    expect_now("dec_0001", 1'b1, 1'b0, 1'b1, 16'h0001);
    cycles(4);
    expect_now("expire", 1'b0, 1'b1, 1'b1, 16'h0000);
`ifdef KTIMER_BEEP_EN
    chk_beep("beep_entry", 1'b1);
`endif
    for (int i = 1; i <= 39; i++) begin
      cyc();
`ifdef KTIMER_BEEP_EN
      if (i < 8) chk_beep("beep_pattern", ((i % 4) < 2));
`endif
    end
    expect_now("alarm_hold", 1'b0, 1'b1, 1'b0, 16'h0000);
    cyc();
    expect_now("alarm_end", 1'b0, 1'b0, 1'b1, 16'h0000);
`ifdef KTIMER_BEEP_EN
    chk_beep("beep_idle", 1'b0);
`endif

    // Pause freezes time; resume restarts a full second.
    for (int i = 0; i < 30; i++) pulse(0, 0, 1, 0);
    expect_now("set_0030", 1'b0, 1'b0, 1'b0, 16'h0030);
    pulse(1, 0, 0, 0);
    expect_now("run_0030", 1'b1, 1'b0, 1'b0, 16'h0030);
    cycles(2);
    pulse(1, 0, 0, 0);
    expect_now("pause", 1'b0, 1'b0, 1'b0, 16'h0030);
    cycles(20);
    expect_now("pause_frz", 1'b0, 1'b0, 1'b0, 16'h0030);
    pulse(1, 0, 0, 0);
    expect_now("resume", 1'b1, 1'b0, 1'b0, 16'h0030);
    cycles(3);
    expect_now("resume_pre", 1'b1, 1'b0, 1'b0, 16'h0030);
    cyc();
    expect_now("resume_tick", 1'b1, 1'b0, 1'b1, 16'h0029);

    // Edits in PAUSE, wrap rules, and same-cycle priority.
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    expect_now("pause_min", 1'b0, 1'b0, 1'b0, 16'h0129);
    for (int i = 0; i < 30; i++) pulse(0, 0, 1, 0);
    expect_now("sec_59", 1'b0, 1'b0, 1'b0, 16'h0159);
    pulse(0, 0, 1, 0);
    expect_now("sec_wrap", 1'b0, 1'b0, 1'b0, 16'h0100);
    for (int i = 0; i < 58; i++) pulse(0, 1, 0, 0);
    expect_now("min_59", 1'b0, 1'b0, 1'b0, 16'h5900);
    pulse(0, 1, 0, 0);
    expect_now("min_wrap", 1'b0, 1'b0, 1'b0, 16'h0000);
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 1);
    expect_now("clr_prio", 1'b0, 1'b0, 1'b0, 16'h0000);

    // btn_start at 00:00 in IDLE is ignored.
    pulse(1, 0, 0, 0);
    expect_now("start_zero", 1'b0, 1'b0, 1'b0, 16'h0000);
    cycles(5);
    expect_now("idle_quiet", 1'b0, 1'b0, 1'b0, 16'h0000);

    // btn_min outranks btn_sec in the same cycle.
    pulse(0, 1, 1, 0);
    expect_now("min_over_sec", 1'b0, 1'b0, 1'b0, 16'h0100);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
